// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg
//   Shared vending-machine definitions used by the change dispenser:
//   - AMOUNT_W      : width of a balance counted in 50-won units
//   - W1000..W50    : weight of each coin in 50-won units
//   - D1000..D50    : bit position of each coin in a one-hot choice vector
//   - state_t       : state encoding of the change dispenser FSM
//   - denomWeight() : maps a one-hot coin choice to its weight
// ---------------------------------------------------------------------------
package vm_pkg;

    localparam int AMOUNT_W = 7;

    localparam logic [AMOUNT_W-1:0] W1000 = 7'd20;
    localparam logic [AMOUNT_W-1:0] W500  = 7'd10;
    localparam logic [AMOUNT_W-1:0] W100  = 7'd2;
    localparam logic [AMOUNT_W-1:0] W50   = 7'd1;

    localparam int D1000 = 3;
    localparam int D500  = 2;
    localparam int D100  = 1;
    localparam int D50   = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // An all-zero choice maps to weight 0 so an empty selection never
    // changes the balance.
    function automatic logic [AMOUNT_W-1:0] denomWeight(input logic [3:0] oneHot);
        logic [AMOUNT_W-1:0] w;
        w = '0;
        if (oneHot[D1000])      w = W1000;
        else if (oneHot[D500])  w = W500;
        else if (oneHot[D100])  w = W100;
        else if (oneHot[D50])   w = W50;
        return w;
    endfunction

endpackage

// File: rtl/coin_select.sv
// ---------------------------------------------------------------------------
// coin_select
//   Combinational greedy picker: chooses the largest coin whose weight fits
//   in the remaining balance and that is still in stock.
//   Ports:
//     remain_i   [7]  balance still owed, 50-won units
//     stockOk_i  [4]  per-coin "stock not empty" flags (one-hot bit order)
//     choice_o   [4]  one-hot coin choice, all zero when nothing fits
//     none_o          no coin fits the balance with the available stock
// ---------------------------------------------------------------------------
module coin_select
    import vm_pkg::*;
(
    input  logic [AMOUNT_W-1:0] remain_i,
    input  logic [3:0]          stockOk_i,
    output logic [3:0]          choice_o,
    output logic                none_o
);

    always_comb begin
        choice_o = '0;
        if (remain_i >= W1000 && stockOk_i[D1000])      choice_o[D1000] = 1'b1;
        else if (remain_i >= W500 && stockOk_i[D500])   choice_o[D500]  = 1'b1;
        else if (remain_i >= W100 && stockOk_i[D100])   choice_o[D100]  = 1'b1;
        else if (remain_i >= W50 && stockOk_i[D50])     choice_o[D50]   = 1'b1;
        none_o = (choice_o == 4'b0000);
    end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//   Pays out a balance (50-won units) as greedy coin-eject pulses,
//   1000 -> 500 -> 100 -> 50 won, one coin per PULSE state.
//   Define CHANGE_STOCK_EN to track per-coin stock (skip empty coins,
//   report Short, honour Refill); otherwise stock is unlimited.
//   Ports:
//     CLK, RST            clock, asynchronous active-high reset
//     Start, Amount[7]    request and balance, sampled only in IDLE
//     Refill              reload every stock counter to STOCK_INIT
//     Return50..1000      one-cycle coin-eject pulses
//     Busy, Done          not-idle flag, one-cycle completion pulse
//     Remain[7]           balance not yet paid out
//     Short               sticky: payout could not be completed
// ---------------------------------------------------------------------------
module change_dispenser
    import vm_pkg::*;
#(
    parameter int PULSE_GAP  = 2,
    parameter int STOCK_INIT = 20,
    parameter int STOCK_W    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start,
    input  logic [AMOUNT_W-1:0] Amount,
    input  logic                Refill,
    output logic                Return50,
    output logic                Return100,
    output logic                Return500,
    output logic                Return1000,
    output logic                Busy,
    output logic                Done,
    output logic [AMOUNT_W-1:0] Remain,
    output logic                Short
);

    // The gap counter runs PULSE_GAP-1 down to 0, so it only needs enough
    // bits to hold PULSE_GAP-1.
    localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (PULSE_GAP > 0) ? GAP_W'(PULSE_GAP - 1) : '0;

    state_t              state_q, state_d;
    logic [AMOUNT_W-1:0] remain_q, remain_d;
    logic [3:0]          sel_q, sel_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [3:0]          choice;
    logic                noneFits;
    logic [3:0]          stockOk;
    logic [AMOUNT_W-1:0] selWeight;

    assign selWeight = denomWeight(sel_q);

    coin_select uCoinSelect (
        .remain_i  (remain_q),
        .stockOk_i (stockOk),
        .choice_o  (choice),
        .none_o    (noneFits)
    );

`ifdef CHANGE_STOCK_EN
    logic [STOCK_W-1:0] stock_q [4];
    logic [STOCK_W-1:0] stock_d [4];
    logic               short_q, short_d;

    // Coin leaves the stock on its pulse; a simultaneous Refill overrides it.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stock_d[i] = stock_q[i];
            if (state_q == ST_PULSE && sel_q[i])
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            if (Refill)
                stock_d[i] = STOCK_W'(STOCK_INIT);
            stockOk[i] = (stock_q[i] != '0);
        end
    end

    // Short is cleared by an accepted Start and set when SELECT finds no coin.
    always_comb begin
        short_d = short_q;
        if (state_q == ST_IDLE && Start)
            short_d = 1'b0;
        else if (state_q == ST_SELECT && noneFits)
            short_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++)
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            short_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                stock_q[i] <= stock_d[i];
            short_q <= short_d;
        end
    end

    assign Short = short_q;
`else
    logic unusedRefill;

    assign unusedRefill = Refill;
    assign stockOk      = 4'b1111;
    assign Short        = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic. PULSE compares against the pre-subtraction balance
    // so the DONE decision does not wait for the new Remain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start)
                    state_d = (Amount == '0) ? ST_DONE : ST_SELECT;
            end
            ST_SELECT: begin
                state_d = noneFits ? ST_DONE : ST_PULSE;
            end
            ST_PULSE: begin
                if (remain_q == selWeight)
                    state_d = ST_DONE;
                else if (PULSE_GAP == 0)
                    state_d = ST_SELECT;
                else
                    state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == '0)
                    state_d = ST_SELECT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: balance load/subtract, coin choice latch and
    // inter-pulse gap countdown.
    always_comb begin
        remain_d = remain_q;
        sel_d    = sel_q;
        gap_d    = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (Start)
                    remain_d = Amount;
            end
            ST_SELECT: begin
                sel_d = choice;
            end
            ST_PULSE: begin
                remain_d = remain_q - selWeight;
                gap_d    = GAP_LOAD;
            end
            ST_GAP: begin
                if (gap_q != '0)
                    gap_d = gap_q - GAP_W'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            remain_q <= '0;
            sel_q    <= '0;
            gap_q    <= '0;
        end else begin
            remain_q <= remain_d;
            sel_q    <= sel_d;
            gap_q    <= gap_d;
        end
    end

    // Outputs decode registered state only; sel_q is one-hot so at most one
    // Return line can be high.
    always_comb begin
        Busy       = (state_q != ST_IDLE);
        Done       = (state_q == ST_DONE);
        Return1000 = (state_q == ST_PULSE) && sel_q[D1000];
        Return500  = (state_q == ST_PULSE) && sel_q[D500];
        Return100  = (state_q == ST_PULSE) && sel_q[D100];
        Return50   = (state_q == ST_PULSE) && sel_q[D50];
        Remain     = remain_q;
    end

endmodule
